// File: rtl/wr_stream_uart_tx.sv
// wr_stream_uart_tx: buffers bytes from the shared write stream in a small FIFO
// and sends them on an 8N1 UART line, LSB first. Reports FIFO occupancy, a full
// flag and a sticky overflow flag so lost bytes can be detected upstream.
module wr_stream_uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = AW + 1;
    localparam int BW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNT_W-1:0] count_next;

    logic            push;
    logic            pop;
    logic            baud_done;

    // Decide this cycle's FIFO push/pop and the next occupancy value.
    always_comb begin
        baud_done  = (baud_cnt == BAUD_LAST);
        push       = wr_en && !fifo_full;
        pop        = (fifo_count != '0) &&
                     ((state == IDLE) || ((state == STOP) && baud_done));
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + CNT_W'(1);
            2'b01:   count_next = fifo_count - CNT_W'(1);
            default: count_next = fifo_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, registered occupancy/full flags and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
            fifo_count <= count_next;
            fifo_full  <= (count_next == DEPTH_CNT);
        end
    end

    // Frame serialiser: start bit, eight data bits LSB first, stop bit, with tx registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Busy while a frame is on the line or bytes are still waiting.
    always_comb begin
        busy = (state != IDLE) || (fifo_count != '0);
    end

endmodule

// File: doc/wr_stream_uart_tx.md
Name: wr_stream_uart_tx

Overview:
- Consumer end of the shared 8-bit wr_en/wr_data write stream produced by the source-select stage (scan / control / gate sources).
- Buffers accepted bytes in a small FIFO and serialises them onto a UART line: 8N1 format, LSB first.
- Reports occupancy, a full flag and a sticky overflow flag so upstream logic and debug can detect lost bytes.

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division truncated; must be >= 2.
- FIFO_DEPTH, 16: byte capacity. Must be a power of two, >= 2.

Ports:
- clk  input  1: single clock; all logic is rising-edge.
- reset  input  1: asynchronous, active-low reset (0 = reset).
- wr_en  input  1: byte-valid strobe; one byte per cycle while high.
- wr_data  input  8: byte accompanying wr_en.
- tx  output  1: UART serial line, idle high.
- busy  output  1: high while a frame is in progress or the FIFO is non-empty.
- fifo_full  output  1: FIFO holds FIFO_DEPTH bytes.
- fifo_count  output  $clog2(FIFO_DEPTH)+1: bytes currently buffered.
- overflow  output  1: sticky; set when a write is dropped.

Behaviour:
- Reset, asynchronous, while reset=0:
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers and the baud counter clear.
  - Reset asserted mid-frame aborts the frame immediately: tx returns to 1 and buffered bytes are discarded.
- FIFO write:
  - At a clk edge with wr_en=1 and fifo_full=0 (value before the edge), wr_data is stored.
  - With wr_en=1 and fifo_full=1, the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge.
- overflow clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. fifo_count updates as:
  - +1 on write only
  - -1 on pop only
  - unchanged when a write and a pop occur on the same edge.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - IDLE: tx=1. On an edge with fifo_count!=0, pop the head byte into the shift register, go to START, tx<=0.
    - Latency: a byte written at edge N into an empty FIFO, with the FSM in IDLE, drives tx low after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx<=bit0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with tx<=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At completion:
    - if fifo_count!=0: pop, go to START, tx<=0 (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Timing: tx is driven from a register (glitch-free). fifo_full and fifo_count are registered. busy is (state!=IDLE) || (fifo_count!=0).
- Writes are accepted in every FSM state; serialisation never stalls the write port unless the FIFO is full.

Test Plan (CLK_FREQ=400, BAUD=100, so CLKS_PER_BIT=4; FIFO_DEPTH=4):
- Reset values: hold reset=0 for 3 cycles, release -> tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0.
- Single byte: write 8'hA5 at edge N.
  - tx low after edge N+1 for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop high for 4 cycles, then IDLE; busy falls after 40 cycles of frame.
- Burst: write 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - fifo_count peaks at 2.
  - Three frames run back-to-back with no idle gap: total 120 cycles of tx activity, decoded bytes 01, 02, 03.
- Overflow: write 6 bytes 10..15 on consecutive cycles from IDLE.
  - First byte popped; 11..14 fill the FIFO, fifo_full=1.
  - 15 is dropped, overflow=1.
  - Line carries 10, 11, 12, 13, 14 only; overflow stays 1 afterwards.
- Simultaneous write/pop: while full, a write coincides with the STOP-end pop -> write dropped, overflow=1, fifo_count goes 4->3.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hFF with 2 bytes queued -> tx=1 at once, fifo_count=0, busy=0; no further frames after release.
